conv_window_gen: RTL and testbench
==================================

Name: conv_window_gen

Overview:
- Sits between the raster pixel stream and the convolution datapath of the on-chip feature extractor.
- Takes a row-major greyscale image one pixel per handshake and stores the last three image rows internally.
- Emits every 3x3 sliding window (stride 1) as a single 9-tap vector with valid/ready flow control.
- Replaces manual read-address sequencing of separate line buffers with a self-contained fill/emit scheduler.

Parameters:
- input_width, 8, bits per pixel.
- im_dim, 28, image width and height in pixels (square image, ≥ 4).

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- pix_data  input  input_width  incoming pixel, row-major order.
- pix_valid  input  1  pix_data is valid.
- pix_ready  output  1  block accepts a pixel this cycle.
- win_data  output  9*input_width  window; tap k=3*i+j sits at bits [k*input_width +: input_width]; i is the row offset (0 = top), j is the column offset (0 = left).
- win_valid  output  1  win_data, win_row and win_col are valid.
- win_ready  input  1  consumer accepts the window.
- win_row  output  $clog2(im_dim)  output-row coordinate of the window.
- win_col  output  $clog2(im_dim)  output-column coordinate of the window.
- frame_done  output  1  one-cycle pulse after the last window of a frame is accepted.

Behaviour:
- Clock and reset: single clock clk_i; asynchronous active-low reset rst_ni.
- Reset values:
  - pix_ready=0, win_valid=0, win_data=0, win_row=0, win_col=0, frame_done=0.
  - All counters and row storage cleared; state=IDLE.
- Storage: three rows of im_dim pixels, used circularly. Physical slot = image row mod 3. Rows are never copied.
- Input handshake: a pixel is accepted when pix_valid && pix_ready. Column and row counters then advance, with column wrapping at im_dim-1.
- Output handshake:
  - win_valid, once set, stays high until win_valid && win_ready.
  - win_data, win_row and win_col stay stable while win_valid && !win_ready.
  - The output register reloads when !win_valid || win_ready. This allows 1 window/cycle throughput.
- FSM (pix_ready is registered, high only in FILL and LOAD):
  - IDLE -> FILL one cycle after reset release.
  - FILL: accept rows 0..2. The cycle after the last pixel of row 2 (pixel 3*im_dim-1) is accepted, go to EMIT with output row r=0.
  - EMIT: pix_ready=0. Issue windows c=0..im_dim-3 for rows r..r+2.
  - EMIT exit: after window c=im_dim-3 is accepted, go to LOAD if r<im_dim-3, else go to DONE.
  - LOAD: accept one row (row r+3), overwriting slot (r mod 3). After its last pixel, r increments and the FSM returns to EMIT.
  - DONE: pulse frame_done for one cycle, clear counters, go to FILL.
- Latency: the first win_valid rises 2 cycles after the handshake of the final pixel of row 2.
- Frame totals: with pix_valid and win_ready held high, a frame yields exactly (im_dim-2)^2 windows (676 at default). Order is win_row major, win_col minor.
- Input is never accepted during EMIT. The producer is stalled by pix_ready=0 and no pixel is dropped.
- Reset mid-frame: immediate return to reset values. The partial frame is discarded; the next accepted pixel is row 0, col 0.
- No arithmetic is performed: taps are raw stored pixels, width unchanged.

Optional Feature:
- Macro: CONV_WINDOW_GEN_ZERO_PAD_EN.
- Defined ("same" padding):
  - Emits im_dim x im_dim windows centred on each pixel. win_row/win_col give the centre pixel.
  - Taps outside the image read 0.
  - Schedule: FILL loads rows 0..1, then EMIT centre row 0 (top taps zero). Then LOAD row r+2 / EMIT centre row r+1 repeats until row im_dim-1 is loaded and centre row im_dim-2 is emitted.
  - Then EMIT centre row im_dim-1 with bottom taps zero and no LOAD, then DONE.
  - Frame total: im_dim^2 windows.
- Undefined: valid-only behaviour as described above.

Test Plan:
- Reset release, pix_valid=0 -> pix_ready=0 in the first cycle, 1 from the second cycle; win_valid=0, frame_done=0.
- Stream pixel value = (row*im_dim+col) mod 256, with pix_valid and win_ready held high -> 676 windows.
  - Window (0,0) taps = {0,1,2,28,29,30,56,57,58}.
  - Window (25,25) taps = {725,726,727,753,754,755,781,782,783} mod 256.
  - frame_done pulses exactly once, 1 cycle after the last window is accepted.
- win_ready toggled randomly at 50% -> every window held stable while stalled; the same 676 windows appear in the same order; pix_ready=0 throughout EMIT.
- pix_valid gapped (1 of every 3 cycles) -> identical window sequence; the first window arrives 2 cycles after pixel 83 is accepted.
- rst_ni pulsed low mid-row 10 -> outputs return to reset values; the subsequent full frame produces the correct 676 windows starting at (0,0).
- With CONV_WINDOW_GEN_ZERO_PAD_EN -> 784 windows.
  - Window (0,0) taps = {0,0,0,0,0,1,0,28,29}.
  - Window (27,27) bottom row and right column taps are 0.

Source files
------------

// File: rtl/conv_window_gen.sv
// 3x3 sliding-window generator over a row-major pixel stream, backed by three circular line buffers.
// Define CONV_WINDOW_GEN_ZERO_PAD_EN for "same" (zero-padded) windows centred on every pixel.
module conv_window_gen #(
  parameter int input_width = 8,
  parameter int im_dim      = 28
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [input_width-1:0]    pix_data,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  output logic [9*input_width-1:0]  win_data,
  output logic                      win_valid,
  input  logic                      win_ready,
  output logic [$clog2(im_dim)-1:0] win_row,
  output logic [$clog2(im_dim)-1:0] win_col,
  output logic                      frame_done
);

  localparam int idx_w = $clog2(im_dim);
  localparam int cnt_w = $clog2(im_dim + 1);

`ifdef CONV_WINDOW_GEN_ZERO_PAD_EN
  localparam int fill_rows    = 2;
  localparam int win_per_row  = im_dim;
  localparam int last_out_row = im_dim - 1;
`else
  localparam int fill_rows    = 3;
  localparam int win_per_row  = im_dim - 2;
  localparam int last_out_row = im_dim - 3;
`endif

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    EMIT,
    LOAD,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [input_width-1:0] line_mem [3][im_dim];

  // Write side: column/row of the next incoming pixel and the slot it lands in.
  logic [idx_w-1:0] in_col_q;
  logic [cnt_w-1:0] in_row_q;
  logic [1:0]       in_slot_q;

  // Read side: output row (top row, or centre row when padded), next column, slot of that row.
  logic [cnt_w-1:0] out_row_q;
  logic [cnt_w-1:0] out_col_q;
  logic [1:0]       base_slot_q;

  logic [9*input_width-1:0] tap_vec;

  logic pix_fire;
  logic in_row_end;
  logic win_fire;
  logic out_free;
  logic row_issued;
  logic win_load;
  logic emit_end;
  logic row_advance;

  function automatic logic [1:0] slot_add(input logic [1:0] base, input int k);
    logic [2:0] s;
    s = 3'(base) + 3'(k);
    if (s >= 3'd3) s = s - 3'd3;
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  assign pix_fire    = pix_valid && pix_ready;
  assign in_row_end  = pix_fire && (in_col_q == idx_w'(im_dim - 1));
  assign win_fire    = win_valid && win_ready;
  assign out_free    = !win_valid || win_ready;
  assign row_issued  = (out_col_q == cnt_w'(win_per_row));
  assign win_load    = (state_q == EMIT) && !row_issued && out_free;
  // A row is finished only once its last window has left the output register.
  assign emit_end    = (state_q == EMIT) && row_issued && out_free;
  assign row_advance = ((state_q == LOAD) && in_row_end) ||
                       (emit_end && (state_d == EMIT));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: every signal driven from always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = FILL;
      FILL: if (in_row_end && (in_row_q == cnt_w'(fill_rows - 1))) state_d = EMIT;
      EMIT: begin
        if (emit_end) begin
          if (in_row_q < cnt_w'(im_dim))              state_d = LOAD;
          else if (out_row_q < cnt_w'(last_out_row))  state_d = EMIT;
          else                                        state_d = DONE;
        end
      end
      LOAD: if (in_row_end) state_d = EMIT;
      DONE: state_d = FILL;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the line buffers are cleared by reset so a restarted frame never exposes stale pixels.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pix_ready   <= 1'b0;
      frame_done  <= 1'b0;
      in_col_q    <= '0;
      in_row_q    <= '0;
      in_slot_q   <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      base_slot_q <= '0;
      for (int s = 0; s < 3; s++) begin
        for (int c = 0; c < im_dim; c++) begin
          line_mem[s][c] <= '0;
        end
      end
    end else begin
      pix_ready  <= (state_d == FILL) || (state_d == LOAD);
      frame_done <= (state_d == DONE);
      if (state_q == DONE) begin
        in_col_q    <= '0;
        in_row_q    <= '0;
        in_slot_q   <= '0;
        out_row_q   <= '0;
        out_col_q   <= '0;
        base_slot_q <= '0;
      end else begin
        if (pix_fire) begin
          line_mem[in_slot_q][in_col_q] <= pix_data;
          if (in_row_end) begin
            in_col_q  <= '0;
            in_row_q  <= in_row_q + 1'b1;
            in_slot_q <= slot_add(in_slot_q, 1);
          end else begin
            in_col_q  <= in_col_q + 1'b1;
          end
        end
        if (win_load) begin
          out_col_q <= out_col_q + 1'b1;
        end
        if (row_advance) begin
          out_row_q   <= out_row_q + 1'b1;
          base_slot_q <= slot_add(base_slot_q, 1);
          out_col_q   <= '0;
        end else if (emit_end) begin
          out_col_q   <= '0;
        end
      end
    end
  end

`ifdef CONV_WINDOW_GEN_ZERO_PAD_EN
  // Row offset i maps to image row out_row+i-1, i.e. slot base+i-1 (mod 3); off-image taps read 0.
  always_comb begin
    tap_vec = '0;
    if (!row_issued) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          if (!((i == 0 && out_row_q == '0) ||
                (i == 2 && out_row_q == cnt_w'(im_dim - 1)) ||
                (j == 0 && out_col_q == '0) ||
                (j == 2 && out_col_q == cnt_w'(im_dim - 1)))) begin
            tap_vec[(3*i+j)*input_width +: input_width] =
              line_mem[slot_add(base_slot_q, i + 2)][idx_w'(out_col_q + cnt_w'(j) - cnt_w'(1))];
          end
        end
      end
    end
  end
`else
  // Row offset i maps to image row out_row+i, held in slot base+i (mod 3).
  always_comb begin
    tap_vec = '0;
    if (!row_issued) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          tap_vec[(3*i+j)*input_width +: input_width] =
            line_mem[slot_add(base_slot_q, i)][idx_w'(out_col_q + cnt_w'(j))];
        end
      end
    end
  end
`endif

  // Output register: reloads whenever empty or being drained, holds otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win_valid <= 1'b0;
      win_data  <= '0;
      win_row   <= '0;
      win_col   <= '0;
    end else if (win_load) begin
      win_valid <= 1'b1;
      win_data  <= tap_vec;
      win_row   <= idx_w'(out_row_q);
      win_col   <= idx_w'(out_col_q);
    end else if (win_fire) begin
      win_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen: window coordinates and taps are predicted from an image
// array, the flow-control rules are checked every cycle, and spot windows come from a constant table.
module tb_conv_window_gen;

  localparam int W  = 8;
  localparam int D  = 28;
  localparam int RW = $clog2(D);
`ifdef CONV_WINDOW_GEN_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif
  localparam int NCOL    = PAD ? D : D - 2;
  localparam int NWIN    = NCOL * NCOL;
  localparam int LAT_PIX = (PAD ? 2 : 3) * D - 1;

  logic            clk_i;
  logic            rst_ni;
  logic [W-1:0]    pix_data;
  logic            pix_valid;
  logic            pix_ready;
  logic [9*W-1:0]  win_data;
  logic            win_valid;
  logic            win_ready;
  logic [RW-1:0]   win_row;
  logic [RW-1:0]   win_col;
  logic            frame_done;

  conv_window_gen #(
    .input_width(W),
    .im_dim     (D)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .win_data  (win_data),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_row   (win_row),
    .win_col   (win_col),
    .frame_done(frame_done)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    int             row;
    int             col;
    logic [9*W-1:0] taps;
  } vec_t;

  int             checks = 0;
  int             errors = 0;
  int             img [D*D];
  logic [9*W-1:0] cap [NWIN];
  vec_t           tab [5];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Window taps straight from the image: tap 3*i+j is pixel (r+i-off, c+j-off), zero off-image.
  function automatic logic [9*W-1:0] model_win(input int r, input int c);
    logic [9*W-1:0] w;
    int rr, cc, off;
    w   = '0;
    off = PAD ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        rr = r + i - off;
        cc = c + j - off;
        if (rr >= 0 && rr < D && cc >= 0 && cc < D) w[(3*i+j)*W +: W] = W'(img[rr*D+cc]);
      end
    end
    return w;
  endfunction

  task automatic fill_pattern();
    for (int k = 0; k < D*D; k++) img[k] = k % 256;
  endtask

  task automatic fill_random();
    for (int k = 0; k < D*D; k++) img[k] = int'($urandom_range(0, 255));
  endtask

  task automatic reset_check(input string tag);
    check($sformatf("%s_pix_ready", tag),  pix_ready,  0);
    check($sformatf("%s_win_valid", tag),  win_valid,  0);
    check($sformatf("%s_win_data", tag),   win_data,   0);
    check($sformatf("%s_win_row", tag),    win_row,    0);
    check($sformatf("%s_win_col", tag),    win_col,    0);
    check($sformatf("%s_frame_done", tag), frame_done, 0);
  endtask

  // One frame: drive pixels (every gap-th cycle), sink windows (optionally random ready), check all.
  task automatic run_frame(input string tag, input bit rand_ready, input int gap,
                           input int abort_px, input bit cap_en);
    int px = 0, nacc = 0, cyc = 0, lat_cyc = -1, first_v = -1, last_acc = -1;
    int r, c;
    bit done = 1'b0;
    bit stall = 1'b0;
    logic [9*W-1:0] hd = '0;
    logic [RW-1:0] hr = '0, hc = '0;
    while (!done && cyc < 20000) begin
      @(negedge clk_i);
      if (abort_px >= 0 && px >= abort_px) begin
        pix_valid = 1'b0;
        win_ready = 1'b0;
        rst_ni    = 1'b0;
        #1;
        reset_check($sformatf("%s_midrst", tag));
        @(negedge clk_i);
        @(negedge clk_i);
        reset_check($sformatf("%s_held", tag));
        rst_ni = 1'b1;
        return;
      end
      if (stall)
        check($sformatf("%s_hold", tag), {win_valid, win_row, win_col, win_data}, {1'b1, hr, hc, hd});
      if (win_valid && first_v < 0) first_v = cyc;
      if (win_valid) check($sformatf("%s_no_input_in_emit", tag), pix_ready, 0);
      if (frame_done) begin
        check($sformatf("%s_frame_done_at", tag), cyc, last_acc + 1);
        check($sformatf("%s_window_count", tag), nacc, NWIN);
        done = 1'b1;
      end
      win_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      pix_valid = (px < D*D) && (cyc % gap == 0);
      pix_data  = (px < D*D) ? W'(img[px]) : '0;
      if (pix_valid && pix_ready) begin
        if (px == LAT_PIX) lat_cyc = cyc;
        px++;
      end
      if (win_valid && win_ready) begin
        if (nacc < NWIN) begin
          r = nacc / NCOL;
          c = nacc % NCOL;
          check($sformatf("%s_pos_%0d", tag, nacc), {win_row, win_col}, {RW'(r), RW'(c)});
          check($sformatf("%s_taps_%0d_%0d", tag, r, c), win_data, model_win(r, c));
          if (cap_en) cap[nacc] = win_data;
        end else begin
          check($sformatf("%s_extra_window", tag), nacc, NWIN - 1);
        end
        nacc++;
        last_acc = cyc;
      end
      stall = win_valid && !win_ready;
      hd = win_data;
      hr = win_row;
      hc = win_col;
      cyc++;
    end
    check($sformatf("%s_frame_done_seen", tag), done, 1);
    check($sformatf("%s_pixels_consumed", tag), px, D*D);
    check($sformatf("%s_first_latency", tag), first_v, lat_cyc + 2);
    pix_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check($sformatf("%s_single_pulse", tag), frame_done, 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef CONV_WINDOW_GEN_ZERO_PAD_EN
    tab[0] = '{0,  0,  {8'd29, 8'd28, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};
    tab[1] = '{27, 27, {8'd0, 8'd0, 8'd0, 8'd0, 8'd15, 8'd14, 8'd0, 8'd243, 8'd242}};
    tab[2] = '{0,  27, {8'd0, 8'd55, 8'd54, 8'd0, 8'd27, 8'd26, 8'd0, 8'd0, 8'd0}};
    tab[3] = '{27, 0,  {8'd0, 8'd0, 8'd0, 8'd245, 8'd244, 8'd0, 8'd217, 8'd216, 8'd0}};
    tab[4] = '{13, 13, {8'd150, 8'd149, 8'd148, 8'd122, 8'd121, 8'd120, 8'd94, 8'd93, 8'd92}};
`else
    tab[0] = '{0,  0,  {8'd58, 8'd57, 8'd56, 8'd30, 8'd29, 8'd28, 8'd2, 8'd1, 8'd0}};
    tab[1] = '{25, 25, {8'd15, 8'd14, 8'd13, 8'd243, 8'd242, 8'd241, 8'd215, 8'd214, 8'd213}};
    tab[2] = '{0,  25, {8'd83, 8'd82, 8'd81, 8'd55, 8'd54, 8'd53, 8'd27, 8'd26, 8'd25}};
    tab[3] = '{25, 0,  {8'd246, 8'd245, 8'd244, 8'd218, 8'd217, 8'd216, 8'd190, 8'd189, 8'd188}};
    tab[4] = '{10, 13, {8'd95, 8'd94, 8'd93, 8'd67, 8'd66, 8'd65, 8'd39, 8'd38, 8'd37}};
`endif

    rst_ni    = 1'b1;
    pix_valid = 1'b0;
    pix_data  = '0;
    win_ready = 1'b0;
    #2 rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    reset_check("reset");
    rst_ni = 1'b1;
    #1;
    check("release_pix_ready_first", pix_ready, 0);
    @(negedge clk_i);
    check("release_pix_ready_second", pix_ready, 1);
    check("release_win_valid", win_valid, 0);
    check("release_frame_done", frame_done, 0);

    fill_pattern();
    run_frame("flow", 1'b0, 1, -1, 1'b1);
    for (int t = 0; t < 5; t++)
      check($sformatf("table_%0d_%0d", tab[t].row, tab[t].col),
            cap[tab[t].row*NCOL + tab[t].col], tab[t].taps);

    run_frame("stall", 1'b1, 1, -1, 1'b0);
    run_frame("gap3", 1'b0, 3, -1, 1'b0);
    fill_random();
    run_frame("rand", 1'b1, 2, -1, 1'b0);
    fill_pattern();
    run_frame("abort", 1'b1, 1, 10*D + 5, 1'b0);
    run_frame("post_rst", 1'b0, 1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
